// File: rtl/cdp_rdma_group_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdp_rdma_group_ctrl_pkg: shared encodings for the CDP RDMA group ctrl    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cdp_rdma_group_ctrl_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  localparam logic [1:0] FSM_IDLE = 2'd0;
  localparam logic [1:0] FSM_LOAD = 2'd1;
  localparam logic [1:0] FSM_RUN  = 2'd2;
  localparam logic [1:0] FSM_GAP  = 2'd3;

  // A group owned by an active LOAD/RUN reports RUNNING even while its op_en is still set.
  function automatic logic [1:0] group_status(input logic owned_busy, input logic en);
    if (owned_busy) return ST_RUNNING;
    else if (en)    return ST_PENDING;
    else            return ST_IDLE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdp_rdma_group_ctrl_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdp_rdma_group_cnt: loadable down-counter with zero flag (LOAD and GAP)  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cdp_rdma_group_cnt
  import cdp_rdma_group_ctrl_pkg::*;
(
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             zero
);

  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    cnt_nxt = r_cnt;
    if (load)
      cnt_nxt = load_val;
    else if (dec && (r_cnt != '0))
      cnt_nxt = r_cnt - CNT_W'(1);
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst)
      r_cnt <= '0;
    else
      r_cnt <= cnt_nxt;
  end

  assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/cdp_rdma_group_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdp_rdma_group_ctrl: ping-pong group sequencer for the CDP RDMA datapath |
// | Optional: CDP_RDMA_GROUP_PROT_EN adds reg_group_wr / sticky prot_err     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cdp_rdma_group_ctrl
  import cdp_rdma_group_ctrl_pkg::*;
#(
  parameter int LOAD_CYCLES = 1,
  parameter int IDLE_GAP    = 0
) (
  input  logic       nvdla_core_clk,
  input  logic       nvdla_core_rst,
  input  logic       producer,
  input  logic [1:0] op_en_set,
  input  logic       op_done,
`ifdef CDP_RDMA_GROUP_PROT_EN
  input  logic       reg_group_wr,
  output logic       prot_err,
`endif
  output logic       consumer,
  output logic [1:0] status_0,
  output logic [1:0] status_1,
  output logic [1:0] op_en,
  output logic       op_load,
  output logic       op_group,
  output logic       dp_busy,
  output logic [1:0] done_intr
);

  localparam logic [CNT_W-1:0] c_load_init = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_gap_init  = CNT_W'(IDLE_GAP - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_consumer;
  logic [1:0]       r_op_en;
  logic             r_op_load;
  logic             r_dp_busy;
  logic [1:0]       r_done_intr;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_dec;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_zero;
  logic             w_done_fire;
  logic [1:0]       w_cons_mask;
  logic             w_busy_state;
  logic [1:0]       w_status [2];

  cdp_rdma_group_cnt u_cnt (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .load           (w_cnt_load),
    .load_val       (w_cnt_val),
    .dec            (w_cnt_dec),
    .cnt_nxt        (w_cnt_nxt),
    .zero           (w_cnt_zero)
  );

  assign w_cons_mask = r_consumer ? 2'b10 : 2'b01;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_val   = '0;
    w_cnt_dec   = 1'b0;
    w_done_fire = 1'b0;
    case (r_state)
      FSM_IDLE: begin
        if ((r_op_en & w_cons_mask) != 2'b00) begin
          w_state_nxt = FSM_LOAD;
          w_cnt_load  = 1'b1;
          w_cnt_val   = c_load_init;
        end
      end
      FSM_LOAD: begin
        if (w_cnt_zero) w_state_nxt = FSM_RUN;
        else            w_cnt_dec   = 1'b1;
      end
      FSM_RUN: begin
        if (op_done) begin
          w_done_fire = 1'b1;
          if (IDLE_GAP > 0) begin
            w_state_nxt = FSM_GAP;
            w_cnt_load  = 1'b1;
            w_cnt_val   = c_gap_init;
          end else begin
            w_state_nxt = FSM_IDLE;
          end
        end
      end
      FSM_GAP: begin
        if (w_cnt_zero) w_state_nxt = FSM_IDLE;
        else            w_cnt_dec   = 1'b1;
      end
      default: w_state_nxt = FSM_IDLE;
    endcase
  end

  // Completion clear is applied after the set, so a set racing the clear of the same group is lost.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_state     <= FSM_IDLE;
      r_consumer  <= 1'b0;
      r_op_en     <= 2'b00;
      r_op_load   <= 1'b0;
      r_dp_busy   <= 1'b0;
      r_done_intr <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_op_load   <= (w_state_nxt == FSM_LOAD) && (w_cnt_nxt == '0);
      r_dp_busy   <= (w_state_nxt == FSM_LOAD) || (w_state_nxt == FSM_RUN);
      r_done_intr <= w_done_fire ? w_cons_mask : 2'b00;
      r_op_en     <= (r_op_en | op_en_set) & ~(w_done_fire ? w_cons_mask : 2'b00);
      if (w_done_fire)
        r_consumer <= ~r_consumer;
    end
  end

  assign w_busy_state = (r_state == FSM_LOAD) || (r_state == FSM_RUN);
  assign w_status[0]  = group_status(w_busy_state && !r_consumer, r_op_en[0]);
  assign w_status[1]  = group_status(w_busy_state &&  r_consumer, r_op_en[1]);

  assign consumer  = r_consumer;
  assign op_group  = r_consumer;
  assign op_en     = r_op_en;
  assign op_load   = r_op_load;
  assign dp_busy   = r_dp_busy;
  assign done_intr = r_done_intr;
  assign status_0  = w_status[0];
  assign status_1  = w_status[1];

`ifdef CDP_RDMA_GROUP_PROT_EN
  logic r_prot_err;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst)
      r_prot_err <= 1'b0;
    else if (reg_group_wr && (w_status[producer] != ST_IDLE))
      r_prot_err <= 1'b1;
  end

  assign prot_err = r_prot_err;
`else
  logic w_unused_producer;
  assign w_unused_producer = producer;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdp_rdma_group_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cdp_rdma_group_ctrl: vectors, corner sequences and random vs model    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cdp_rdma_group_ctrl;

  localparam int LC [2] = '{1, 3};
  localparam int GP [2] = '{0, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       producer = 1'b0;
  logic [1:0] op_en_set = 2'b00;
  logic       op_done = 1'b0;
  logic       reg_group_wr = 1'b0;

  logic       o_cons [2];
  logic [1:0] o_s0   [2];
  logic [1:0] o_s1   [2];
  logic [1:0] o_en   [2];
  logic       o_load [2];
  logic       o_grp  [2];
  logic       o_busy [2];
  logic [1:0] o_done [2];
  logic       o_prot [2];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  cdp_rdma_group_ctrl #(.LOAD_CYCLES(1), .IDLE_GAP(0)) u_a (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .producer       (producer),
    .op_en_set      (op_en_set),
    .op_done        (op_done),
`ifdef CDP_RDMA_GROUP_PROT_EN
    .reg_group_wr   (reg_group_wr),
    .prot_err       (o_prot[0]),
`endif
    .consumer       (o_cons[0]),
    .status_0       (o_s0[0]),
    .status_1       (o_s1[0]),
    .op_en          (o_en[0]),
    .op_load        (o_load[0]),
    .op_group       (o_grp[0]),
    .dp_busy        (o_busy[0]),
    .done_intr      (o_done[0])
  );

  cdp_rdma_group_ctrl #(.LOAD_CYCLES(3), .IDLE_GAP(2)) u_b (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .producer       (producer),
    .op_en_set      (op_en_set),
    .op_done        (op_done),
`ifdef CDP_RDMA_GROUP_PROT_EN
    .reg_group_wr   (reg_group_wr),
    .prot_err       (o_prot[1]),
`endif
    .consumer       (o_cons[1]),
    .status_0       (o_s0[1]),
    .status_1       (o_s1[1]),
    .op_en          (o_en[1]),
    .op_load        (o_load[1]),
    .op_group       (o_grp[1]),
    .dp_busy        (o_busy[1]),
    .done_intr      (o_done[1])
  );

  // Reference: hardware either loads (ld = load cycles left), runs, or waits out a gap.
  bit       m_cons [2];
  bit [1:0] m_en   [2];
  int       m_ld   [2];
  bit       m_run  [2];
  int       m_gap  [2];
  bit [1:0] m_done [2];
  bit       m_prot [2];

  function automatic bit [1:0] mstat(input int i, input int g);
    if ((m_ld[i] > 0 || m_run[i]) && (int'(m_cons[i]) == g)) return 2'd1;
    if (m_en[i][g]) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_step(input int i, input bit r, input bit [1:0] s, input bit d,
                            input bit wr, input bit pr);
    bit [1:0] en_n;
    if (r) begin
      m_cons[i] = 0; m_en[i] = 0; m_ld[i] = 0; m_run[i] = 0;
      m_gap[i] = 0; m_done[i] = 0; m_prot[i] = 0;
      return;
    end
    if (wr && mstat(i, int'(pr)) != 2'd0) m_prot[i] = 1;
    en_n = m_en[i] | s;
    m_done[i] = 2'b00;
    if (m_run[i]) begin
      if (d) begin
        en_n[m_cons[i]] = 1'b0;
        m_done[i][m_cons[i]] = 1'b1;
        m_cons[i] = ~m_cons[i];
        m_run[i] = 0;
        m_gap[i] = GP[i];
      end
    end else if (m_ld[i] > 0) begin
      m_ld[i] = m_ld[i] - 1;
      if (m_ld[i] == 0) m_run[i] = 1;
    end else if (m_gap[i] > 0) begin
      m_gap[i] = m_gap[i] - 1;
    end else if (m_en[i][m_cons[i]]) begin
      m_ld[i] = LC[i];
    end
    m_en[i] = en_n;
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_models();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("inst%0d consumer", i),  {3'b0, o_cons[i]}, {3'b0, m_cons[i]});
      chk($sformatf("inst%0d op_group", i),  {3'b0, o_grp[i]},  {3'b0, m_cons[i]});
      chk($sformatf("inst%0d op_en", i),     {2'b0, o_en[i]},   {2'b0, m_en[i]});
      chk($sformatf("inst%0d op_load", i),   {3'b0, o_load[i]}, {3'b0, m_ld[i] == 1});
      chk($sformatf("inst%0d dp_busy", i),   {3'b0, o_busy[i]}, {3'b0, (m_ld[i] > 0) || m_run[i]});
      chk($sformatf("inst%0d done_intr", i), {2'b0, o_done[i]}, {2'b0, m_done[i]});
      chk($sformatf("inst%0d status_0", i),  {2'b0, o_s0[i]},   {2'b0, mstat(i, 0)});
      chk($sformatf("inst%0d status_1", i),  {2'b0, o_s1[i]},   {2'b0, mstat(i, 1)});
`ifdef CDP_RDMA_GROUP_PROT_EN
      chk($sformatf("inst%0d prot_err", i),  {3'b0, o_prot[i]}, {3'b0, m_prot[i]});
`endif
    end
  endtask

  task automatic step(input logic r, input logic [1:0] s, input logic d);
    rst = r; op_en_set = s; op_done = d;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) model_step(i, r, s, d, reg_group_wr, producer);
    compare_models();
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] set;
    logic       done;
    logic       cons;
    logic [1:0] en;
    logic       load;
    logic [1:0] dn;
    logic [1:0] s0;
    logic [1:0] s1;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [1:0] s, input logic d, input logic c,
                     input logic [1:0] e, input logic l, input logic [1:0] dn,
                     input logic [1:0] s0, input logic [1:0] s1, input logic b);
    vec_t v;
    v.rst = r; v.set = s; v.done = d; v.cons = c; v.en = e; v.load = l;
    v.dn = dn; v.s0 = s0; v.s1 = s1; v.busy = b;
    tbl.push_back(v);
  endtask

  initial begin
    int lat;
    bit seen;

    // Expected values for the LOAD_CYCLES=1 / IDLE_GAP=0 instance.
    add(1, 2'b11, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0);   // reset masks set and done
    add(0, 2'b11, 0, 0, 2'b11, 0, 2'b00, 2, 2, 0);   // both pending
    add(0, 2'b00, 0, 0, 2'b11, 1, 2'b00, 1, 2, 1);   // group 0 load
    for (int k = 0; k < 3; k++) add(0, 2'b00, 0, 0, 2'b11, 0, 2'b00, 1, 2, 1);
    add(0, 2'b00, 1, 1, 2'b10, 0, 2'b01, 0, 2, 0);   // group 0 done
    add(0, 2'b00, 0, 1, 2'b10, 1, 2'b00, 0, 1, 1);   // group 1 load back-to-back
    for (int k = 0; k < 5; k++) add(0, 2'b00, 0, 1, 2'b10, 0, 2'b00, 0, 1, 1);
    add(0, 2'b00, 1, 0, 2'b00, 0, 2'b10, 0, 0, 0);   // group 1 done
    add(0, 2'b00, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0);   // done while idle ignored
    add(0, 2'b01, 0, 0, 2'b01, 0, 2'b00, 2, 0, 0);
    add(0, 2'b00, 0, 0, 2'b01, 1, 2'b00, 1, 0, 1);
    add(0, 2'b00, 0, 0, 2'b01, 0, 2'b00, 1, 0, 1);
    add(0, 2'b01, 0, 0, 2'b01, 0, 2'b00, 1, 0, 1);   // re-set during run ignored
    add(0, 2'b00, 1, 1, 2'b00, 0, 2'b01, 0, 0, 0);
    add(0, 2'b10, 0, 1, 2'b10, 0, 2'b00, 0, 2, 0);
    add(0, 2'b00, 0, 1, 2'b10, 1, 2'b00, 0, 1, 1);
    add(0, 2'b00, 0, 1, 2'b10, 0, 2'b00, 0, 1, 1);
    add(0, 2'b10, 1, 0, 2'b00, 0, 2'b10, 0, 0, 0);   // set in completion cycle lost
    add(0, 2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);

    step(1, 2'b00, 0);
    step(1, 2'b00, 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 2'b00, 0);
      chk("idle consumer", {3'b0, o_cons[0]}, 4'h0);
      chk("idle op_load",  {3'b0, o_load[0]}, 4'h0);
      chk("idle status",   {o_s0[0], o_s1[0]}, 4'h0);
      chk("idle op_en",    {2'b0, o_en[0]}, 4'h0);
    end

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].set, tbl[k].done);
      chk($sformatf("vec%0d consumer", k),  {3'b0, o_cons[0]}, {3'b0, tbl[k].cons});
      chk($sformatf("vec%0d op_en", k),     {2'b0, o_en[0]},   {2'b0, tbl[k].en});
      chk($sformatf("vec%0d op_load", k),   {3'b0, o_load[0]}, {3'b0, tbl[k].load});
      chk($sformatf("vec%0d done_intr", k), {2'b0, o_done[0]}, {2'b0, tbl[k].dn});
      chk($sformatf("vec%0d status_0", k),  {2'b0, o_s0[0]},   {2'b0, tbl[k].s0});
      chk($sformatf("vec%0d status_1", k),  {2'b0, o_s1[0]},   {2'b0, tbl[k].s1});
      chk($sformatf("vec%0d dp_busy", k),   {3'b0, o_busy[0]}, {3'b0, tbl[k].busy});
    end

    // LOAD_CYCLES=3, IDLE_GAP=2: set-to-load latency, then done_intr-to-next-load latency.
    step(1, 2'b00, 0);
    step(0, 2'b11, 0);
    lat = 0; seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(0, 2'b00, 0);
      lat++;
      seen = o_load[1];
    end
    chk("b first load latency", 4'(lat), 4'd3);
    step(0, 2'b00, 0);
    step(0, 2'b00, 1);
    chk("b first done_intr", {2'b0, o_done[1]}, 4'b0001);
    lat = 0; seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(0, 2'b00, 0);
      lat++;
      seen = o_load[1];
    end
    chk("b second load latency", 4'(lat), 4'd5);
    chk("b second load group", {3'b0, o_grp[1]}, 4'h1);

`ifdef CDP_RDMA_GROUP_PROT_EN
    step(1, 2'b00, 0);
    step(0, 2'b01, 0);
    step(0, 2'b00, 0);
    step(0, 2'b00, 0);
    producer = 1'b0; reg_group_wr = 1'b1;
    step(0, 2'b00, 0);
    reg_group_wr = 1'b0;
    chk("prot set", {3'b0, o_prot[0]}, 4'h1);
    for (int k = 0; k < 3; k++) step(0, 2'b00, 0);
    chk("prot sticky", {3'b0, o_prot[0]}, 4'h1);
    step(1, 2'b00, 0);
    reg_group_wr = 1'b1;
    step(0, 2'b00, 0);
    reg_group_wr = 1'b0;
    step(0, 2'b00, 0);
    chk("prot idle", {3'b0, o_prot[0]}, 4'h0);
`endif

    step(1, 2'b00, 0);
    for (int k = 0; k < 2500; k++) begin
      logic       r;
      logic [1:0] s;
      logic       d;
      r = ($urandom_range(0, 149) == 0);
      s[0] = ($urandom_range(0, 7) == 0);
      s[1] = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 5) == 0);
      producer = 1'($urandom_range(0, 1));
      reg_group_wr = ($urandom_range(0, 9) == 0);
      step(r, s, d);
    end
    reg_group_wr = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
